// File: rtl/cnn_div_seq_25s_14s_pkg.sv
// Shared fixed-point helpers for the CNN requantisation path: divider FSM states,
// default operand widths, and the abs / saturating-narrow helpers.
package cnn_fixed_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int DIV_DIVIDEND_W = 25;
  localparam int DIV_DIVISOR_W  = 14;
  localparam int DIV_QUOT_W     = 10;

  // Magnitude of a sign-extended operand; callers size-cast the result back down.
  function automatic logic [31:0] abs_s(input logic signed [31:0] v);
    return (v < 0) ? 32'(-v) : 32'(v);
  endfunction

  // Clamp v into the signed range of a w-bit value.
  function automatic logic signed [31:0] sat_narrow(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cnn_div_seq_25s_14s_if.sv
// Operand/result handshake bundle for the sequential divider; slave is the divider side.
interface cnn_div_seq_25s_14s_if
  import cnn_fixed_pkg::*;
#(
  parameter int din0_WIDTH = DIV_DIVIDEND_W,
  parameter int din1_WIDTH = DIV_DIVISOR_W,
  parameter int dout_WIDTH = DIV_QUOT_W
);
  logic                  in_valid;
  logic                  in_ready;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  out_valid;
  logic                  out_ready;
  logic [dout_WIDTH-1:0] dout;
  logic [din1_WIDTH-1:0] rem;
  logic                  div0;

  modport master (
    output in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, dout, rem, div0
  );

  modport slave (
    input  in_valid, din0, din1, out_ready,
    output in_ready, out_valid, dout, rem, div0
  );
endinterface

// File: rtl/cnn_div_seq_25s_14s_step.sv
// One combinational restoring-division step on magnitudes: shift in the next dividend
// bit, trial-subtract the divisor, keep the difference when it does not go negative.
module cnn_div_step
  import cnn_fixed_pkg::*;
#(
  parameter int DW = DIV_DIVISOR_W
) (
  input  logic [DW-1:0] i_rem,
  input  logic          i_bit,
  input  logic [DW-1:0] i_den,
  output logic [DW-1:0] o_rem,
  output logic          o_qbit
);
  logic [DW:0]   w_shift;
  logic [DW-1:0] w_diff;

  assign w_shift = {i_rem, i_bit};
  // Only taken when shift >= den, so the result is below den and the low DW bits suffice.
  assign w_diff  = w_shift[DW-1:0] - i_den;
  assign o_qbit  = (w_shift >= {1'b0, i_den});
  assign o_rem   = o_qbit ? w_diff : w_shift[DW-1:0];
endmodule

// File: rtl/cnn_div_seq_25s_14s.sv
// Signed restoring divider 25s/14s -> 10s quotient + remainder, fixed 26-cycle latency, one op in flight;
// result held until out_ready. Define CNN_DIV_SAT_EN to clamp the quotient instead of wrapping it.
module cnn_div_seq_25s_14s
  import cnn_fixed_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = DIV_DIVIDEND_W,
  parameter int din1_WIDTH = DIV_DIVISOR_W,
  parameter int dout_WIDTH = DIV_QUOT_W
) (
  input logic                  ap_clk,
  input logic                  ap_rst_n,
  cnn_div_seq_25s_14s_if.slave bus
);
  localparam int CW = $clog2(din0_WIDTH);
  localparam int QW = din0_WIDTH + 1;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [din0_WIDTH-1:0]   r_num;
  logic [din1_WIDTH-1:0]   r_den;
  logic [din1_WIDTH-1:0]   r_rem_mag;
  logic                    r_sign_n;
  logic                    r_sign_d;
  logic [CW-1:0]           r_cnt;
  logic [dout_WIDTH-1:0]   r_dout;
  logic [din1_WIDTH-1:0]   r_rem;
  logic                    r_div0;

  logic                    w_in_ready;
  logic                    w_out_valid;
  logic [din1_WIDTH-1:0]   w_step_rem;
  logic                    w_qbit;
  logic signed [QW-1:0]    w_quot_s;
  logic [din1_WIDTH-1:0]   w_rem_s;
  logic                    w_div0;
  logic [dout_WIDTH-1:0]   w_dout;

  cnn_div_step #(.DW(din1_WIDTH)) u_step (
    .i_rem  (r_rem_mag),
    .i_bit  (r_num[din0_WIDTH-1]),
    .i_den  (r_den),
    .o_rem  (w_step_rem),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = CALC;
      end
      CALC:    if (r_cnt == '0) w_state_nxt = FIX;
      FIX:     w_state_nxt = DONE;
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sign fix-up: quotient truncates toward zero, remainder takes the dividend's sign.
  // With a zero divisor every step keeps the shifted value, so r_rem_mag ends as the
  // low bits of |dividend| and re-signing it yields dividend[din1_WIDTH-1:0] directly.
  assign w_quot_s = (r_sign_n ^ r_sign_d) ? -$signed({1'b0, r_num}) : $signed({1'b0, r_num});
  assign w_rem_s  = r_sign_n ? -r_rem_mag : r_rem_mag;
  assign w_div0   = (r_den == '0);

`ifdef CNN_DIV_SAT_EN
  assign w_dout = w_div0 ? (r_sign_n ? {1'b1, {(dout_WIDTH-1){1'b0}}} : {1'b0, {(dout_WIDTH-1){1'b1}}})
                         : dout_WIDTH'(sat_narrow(32'(w_quot_s), dout_WIDTH));
`else
  assign w_dout = w_div0 ? '1 : dout_WIDTH'(w_quot_s);
`endif

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_num     <= '0;
      r_den     <= '0;
      r_rem_mag <= '0;
      r_sign_n  <= 1'b0;
      r_sign_d  <= 1'b0;
      r_cnt     <= '0;
      r_dout    <= '0;
      r_rem     <= '0;
      r_div0    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_num     <= din0_WIDTH'(abs_s(32'($signed(bus.din0))));
          r_den     <= din1_WIDTH'(abs_s(32'($signed(bus.din1))));
          r_sign_n  <= bus.din0[din0_WIDTH-1];
          r_sign_d  <= bus.din1[din1_WIDTH-1];
          r_rem_mag <= '0;
          r_cnt     <= CW'(din0_WIDTH - 1);
        end
        CALC: begin
          r_num     <= {r_num[din0_WIDTH-2:0], w_qbit};
          r_rem_mag <= w_step_rem;
          r_cnt     <= r_cnt - CW'(1);
        end
        FIX: begin
          r_dout <= w_dout;
          r_rem  <= w_rem_s;
          r_div0 <= w_div0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.dout      = r_dout;
  assign bus.rem       = r_rem;
  assign bus.div0      = r_div0;
endmodule
